// File: rtl/mic_fir_mac_engine.sv
// Time-multiplexed single-MAC FIR for the microphone path.
// Coefficients are read from the shared RAM's s2 port; sample history lives in a local delay line.
module mic_fir_mac_engine #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int MAX_TAPS = 256,
    parameter int ACC_W    = 40
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] coef_address,
    output logic              coef_chipselect,
    output logic              coef_clken,
    output logic              coef_write,
    output logic [31:0]       coef_writedata,
    output logic [3:0]        coef_byteenable,
    input  logic [31:0]       coef_readdata,
    input  logic [31:0]       cntl,
    input  logic              soft_rst,
    output logic              busy,
    output logic              overflow
);

    localparam int TAP_W  = $clog2(MAX_TAPS);
    localparam int NW     = TAP_W + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t                     state_q, state_d;
    logic [TAP_W-1:0]           clr_cnt_q, clr_cnt_d;
    logic [TAP_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [TAP_W-1:0]           k_q, k_d;
    logic [NW-1:0]              n_q, n_d;
    logic [3:0]                 sh_q, sh_d;
    logic                       byp_q, byp_d;
    logic                       v1_q, v1_d;
    logic                       v2_q, v2_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]          m_data_q, m_data_d;
    logic                       overflow_q, overflow_d;

    logic [DATA_W-1:0]          dl_mem [MAX_TAPS];
    logic [DATA_W-1:0]          dl_rd_data;
    logic                       dl_we;
    logic [TAP_W-1:0]           dl_waddr;
    logic [TAP_W-1:0]           dl_raddr;
    logic [DATA_W-1:0]          dl_wdata;

    logic                       accept;
    logic                       issue;
    logic                       last_issue;
    logic [31:0]                ntaps_req;
    logic [NW-1:0]              n_clamp;
    logic signed [COEF_W-1:0]   coef_s;
    logic signed [DATA_W-1:0]   smp_s;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          y_sat;
    logic                       clip;
    logic                       unused_ok;

    assign unused_ok = ^{cntl[30:14], cntl[9], coef_readdata[31:COEF_W]};

    assign coef_write      = 1'b0;
    assign coef_writedata  = '0;
    assign coef_byteenable = '1;
    assign coef_clken      = 1'b1;

    assign s_ready         = (state_q == ST_IDLE) && !soft_rst;
    assign accept          = s_ready && s_valid;
    assign m_valid         = (state_q == ST_OUT);
    assign busy            = !((state_q == ST_IDLE) || (state_q == ST_OUT));
    assign issue           = (state_q == ST_MAC);
    assign coef_chipselect = issue;
    assign coef_address    = issue ? ADDR_W'(k_q) : '0;
    assign m_data          = m_data_q;
    assign overflow        = overflow_q;

    assign last_issue = ({1'b0, k_q} + NW'(1)) == n_q;
    assign coef_s     = coef_readdata[COEF_W-1:0];
    assign smp_s      = dl_rd_data;

    assign dl_we    = (state_q == ST_CLEAR) || accept;
    assign dl_waddr = (state_q == ST_CLEAR) ? clr_cnt_q : wr_ptr_q;
    assign dl_wdata = (state_q == ST_CLEAR) ? '0 : s_data;
    assign dl_raddr = wr_ptr_q - k_q;

    always_ff @(posedge clk_clk) begin
        if (dl_we) begin
            dl_mem[dl_waddr] <= dl_wdata;
        end
        dl_rd_data <= dl_mem[dl_raddr];
    end

    always_comb begin
        ntaps_req = {23'd0, cntl[8:0]};
        if (ntaps_req == 32'd0) begin
            n_clamp = NW'(1);
        end else if (ntaps_req > 32'(MAX_TAPS)) begin
            n_clamp = NW'(MAX_TAPS);
        end else begin
            n_clamp = ntaps_req[NW-1:0];
        end
    end

    always_comb begin
        shifted = acc_q >>> sh_q;
        clip    = 1'b0;
        y_sat   = shifted[DATA_W-1:0];
        if (shifted > SAT_HI) begin
            y_sat = {1'b0, {(DATA_W-1){1'b1}}};
            clip  = 1'b1;
        end else if (shifted < SAT_LO) begin
            y_sat = {1'b1, {(DATA_W-1){1'b0}}};
            clip  = 1'b1;
        end
    end

    // Pipeline: issue -> RAM data (v1) -> product register (v2) -> accumulate.
    // DRAIN waits for both stages to empty, giving N+3 edges from accept to m_valid.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        k_d        = k_q;
        n_d        = n_q;
        sh_d       = sh_q;
        byp_d      = byp_q;
        m_data_d   = m_data_q;
        overflow_d = overflow_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        v1_d       = issue;
        v2_d       = v1_q;

        if (v1_q) begin
            prod_d = PROD_W'(coef_s) * PROD_W'(smp_s);
        end
        if (v2_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
        if (issue && (k_q == '0)) begin
            acc_d = '0;
        end

        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + TAP_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    n_d   = n_clamp;
                    sh_d  = cntl[13:10];
                    byp_d = cntl[31];
                    k_d   = '0;
                    if (cntl[31]) begin
                        m_data_d = s_data;
                        state_d  = ST_DRAIN;
                    end else begin
                        state_d = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                k_d = k_q + TAP_W'(1);
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!v1_q && !v2_q) begin
                    state_d = ST_OUT;
                    if (!byp_q) begin
                        m_data_d = y_sat;
                        if (clip) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    wr_ptr_d = wr_ptr_q + TAP_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (soft_rst) begin
            state_d    = ST_CLEAR;
            clr_cnt_d  = '0;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
            v1_d       = 1'b0;
            v2_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            k_q        <= '0;
            n_q        <= NW'(1);
            sh_q       <= '0;
            byp_q      <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            m_data_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            k_q        <= k_d;
            n_q        <= n_d;
            sh_q       <= sh_d;
            byp_q      <= byp_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mic_fir_mac_engine.sv
// Randomized self-checking bench for mic_fir_mac_engine against a plain convolution model.
module tb_mic_fir_mac_engine;

    localparam int MAX_TAPS = 256;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [9:0]  coef_address;
    logic        coef_chipselect;
    logic        coef_clken;
    logic        coef_write;
    logic [31:0] coef_writedata;
    logic [3:0]  coef_byteenable;
    logic [31:0] coef_readdata;
    logic [31:0] cntl;
    logic        soft_rst;
    logic        busy;
    logic        overflow;

    mic_fir_mac_engine #(
        .DATA_W(16), .COEF_W(16), .ADDR_W(10), .MAX_TAPS(MAX_TAPS), .ACC_W(40)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .coef_address(coef_address), .coef_chipselect(coef_chipselect),
        .coef_clken(coef_clken), .coef_write(coef_write),
        .coef_writedata(coef_writedata), .coef_byteenable(coef_byteenable),
        .coef_readdata(coef_readdata),
        .cntl(cntl), .soft_rst(soft_rst), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-loaded coefficient RAM; upper halfword carries junk the engine must ignore.
    logic [31:0] coef_mem [1024];
    logic        trk_clr;
    logic        cs_seen;
    logic [9:0]  max_addr;

    always @(posedge clk) begin
        if (coef_chipselect && coef_clken) coef_readdata <= coef_mem[coef_address];
        if (trk_clr) begin
            cs_seen  <= 1'b0;
            max_addr <= '0;
        end else if (coef_chipselect) begin
            cs_seen <= 1'b1;
            if (coef_address > max_addr) max_addr <= coef_address;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: history newest-first, sticky overflow.
    logic signed [15:0] coefv [MAX_TAPS];
    logic signed [15:0] hist [$];
    bit                 model_ovf;

    task automatic model_clear();
        hist.delete();
        model_ovf = 0;
    endtask

    function automatic int ntaps_of(input logic [31:0] c);
        int n;
        n = int'(c[8:0]);
        if (n == 0) n = 1;
        if (n > MAX_TAPS) n = MAX_TAPS;
        return n;
    endfunction

    task automatic model_step(input logic [15:0] x, input logic [31:0] c, output logic [15:0] y);
        longint acc;
        int     n;
        hist.push_front(x);
        if (hist.size() > MAX_TAPS) void'(hist.pop_back());
        if (c[31]) begin
            y = x;
            return;
        end
        n   = ntaps_of(c);
        acc = 0;
        for (int k = 0; k < n; k++) begin
            if (k < hist.size()) acc += longint'(coefv[k]) * longint'(hist[k]);
        end
        acc = acc >>> c[13:10];
        if (acc > 32767) begin
            y = 16'h7FFF;
            model_ovf = 1;
        end else if (acc < -32768) begin
            y = 16'h8000;
            model_ovf = 1;
        end else begin
            y = acc[15:0];
        end
    endtask

    task automatic set_coef(input int k, input logic [15:0] v);
        coef_mem[k] = {16'($urandom), v};
        if (k < MAX_TAPS) coefv[k] = v;
    endtask

    task automatic wait_clear(input string tag);
        int cyc;
        bit vseen;
        bit bz;
        cyc = 0; vseen = 0; bz = 1;
        while (!s_ready && cyc < 2 * MAX_TAPS) begin
            @(posedge clk); #1;
            cyc++;
            if (m_valid) vseen = 1;
            if (!s_ready && !busy) bz = 0;
        end
        check({tag, "_len"}, cyc, MAX_TAPS);
        check({tag, "_no_valid"}, vseen, 0);
        check({tag, "_busy"}, bz, 1);
    endtask

    task automatic do_soft_rst(input string tag);
        soft_rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ready_low"}, s_ready, 0);
        check({tag, "_busy_high"}, busy, 1);
        @(posedge clk); #1;
        soft_rst = 1'b0;
        wait_clear(tag);
        check({tag, "_ovf_clr"}, overflow, 0);
        model_clear();
    endtask

    task automatic run_sample(input logic [15:0] x, input logic [31:0] c, input int hold);
        int          lat;
        bit          stable;
        logic [15:0] exp;
        logic [15:0] held;
        model_step(x, c, exp);
        check("ready_before", s_ready, 1);
        s_data  = x;
        cntl    = c;
        s_valid = 1'b1;
        m_ready = (hold == 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        cntl    = $urandom;
        lat = 0;
        while (!m_valid && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, c[31] ? 1 : ntaps_of(c) + 3);
        check("m_data", m_data, exp);
        check("overflow", overflow, model_ovf);
        if (hold > 0) begin
            held    = m_data;
            stable  = 1;
            s_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (m_data !== held || !m_valid || s_ready) stable = 0;
            end
            check("backpressure_hold", stable, 1);
            s_valid = 1'b0;
            m_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("m_valid_drop", m_valid, 0);
        check("s_ready_after", s_ready, 1);
    endtask

    initial begin
        logic [31:0] c;
        int          lat;
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        cntl    = '0;
        soft_rst = 1'b0;
        trk_clr = 1'b1;
        for (int k = 0; k < 1024; k++) set_coef(k, (k < MAX_TAPS) ? 16'($urandom) : 16'h0);
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_coef_addr", coef_address, 0);
        check("rst_coef_cs", coef_chipselect, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 1);
        check("const_write", coef_write, 0);
        check("const_wdata", coef_writedata, 0);
        check("const_be", coef_byteenable, 4'hF);
        check("const_clken", coef_clken, 1);
        rst_n = 1'b1;
        trk_clr = 1'b0;
        wait_clear("reset_clear");

        // Impulse through coef k+1
        for (int k = 0; k < 4; k++) set_coef(k, 16'(k + 1));
        run_sample(16'h4000, {18'd0, 4'd14, 10'd4}, 0);
        run_sample(16'h0000, {18'd0, 4'd14, 10'd4}, 0);
        run_sample(16'h0000, {18'd0, 4'd14, 10'd4}, 0);
        run_sample(16'h0000, {18'd0, 4'd14, 10'd4}, 0);
        run_sample(16'h0000, {18'd0, 4'd14, 10'd4}, 0);
        check("impulse_ovf", overflow, 0);

        // Latency 11 and 20 cycles of backpressure
        run_sample(16'($urandom), {18'd0, 4'd15, 10'd8}, 20);

        // Saturation both directions
        do_soft_rst("sat_pre");
        for (int k = 0; k < 4; k++) set_coef(k, 16'h7FFF);
        repeat (4) run_sample(16'h7FFF, {18'd0, 4'd0, 10'd4}, 0);
        check("sat_pos_val", m_data, 16'h7FFF);
        check("sat_pos_ovf", overflow, 1);
        do_soft_rst("sat_mid");
        repeat (4) run_sample(16'h8000, {18'd0, 4'd0, 10'd4}, 0);
        check("sat_neg_val", m_data, 16'h8000);
        check("sat_neg_ovf", overflow, 1);

        // Bypass, then the bypassed sample must be in history
        trk_clr = 1'b1;
        @(posedge clk); #1;
        trk_clr = 1'b0;
        run_sample(16'h1234, 32'h8000_0000, 0);
        check("bypass_no_cs", cs_seen, 0);
        set_coef(0, 16'h0000);
        set_coef(1, 16'h4000);
        run_sample(16'h0000, {18'd0, 4'd14, 10'd2}, 0);

        // Randomized traffic
        for (int k = 0; k < 32; k++) set_coef(k, 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            c = {($urandom_range(7) == 0), 17'd0, 4'($urandom_range(15)), 1'b0, 9'($urandom_range(20))};
            run_sample(16'($urandom), c, int'($urandom_range(3)));
        end

        // Abort at issue k=3
        s_data  = 16'h4000;
        cntl    = {18'd0, 4'd0, 10'd8};
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        while (!(coef_chipselect && coef_address == 10'd3) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("abort_at_k3", coef_address, 3);
        do_soft_rst("abort");

        for (int k = 0; k < 4; k++) set_coef(k, 16'(k + 1));
        repeat (1) run_sample(16'h4000, {18'd0, 4'd14, 10'd4}, 0);
        repeat (4) run_sample(16'h0000, {18'd0, 4'd14, 10'd4}, 0);
        check("clean_ovf", overflow, 0);

        // Tap-count clamping
        run_sample(16'($urandom), {18'd0, 4'd12, 10'd0}, 0);
        trk_clr = 1'b1;
        @(posedge clk); #1;
        trk_clr = 1'b0;
        run_sample(16'($urandom), {18'd0, 4'd15, 10'd511}, 0);
        check("clamp_max_addr", max_addr, 255);

        // Full-length impulse response with delay-line wrap
        do_soft_rst("long_pre");
        for (int k = 0; k < MAX_TAPS; k++) set_coef(k, 16'($urandom));
        run_sample(16'h4000, {18'd0, 4'd14, 10'd256}, 0);
        for (int i = 1; i < 264; i++) run_sample(16'h0000, {18'd0, 4'd14, 10'd256}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
